// File: rtl/player_life_controller.sv
// player_life_controller: game-level sequencer that owns lives, level count,
// death/respawn timing and game-over. It gates the arrow keys toward the
// movement block, requests a position reload on (re)spawn, and drives the
// sprite visibility and death-animation frame index.
// All timed states count startOfFrame pulses in a shared 9-bit counter that
// clears on every state change.
// Handshake note: there is no valid/ready traffic here; respawnReq is a
// registered single-cycle strobe that the movement block consumes
// unconditionally on the cycle it is high.
module player_life_controller #(
  parameter int unsigned INITIAL_LIVES      = 3,
  parameter int unsigned START_DELAY_FRAMES = 32,
  parameter int unsigned DEATH_FRAMES       = 256,
  parameter int unsigned RESPAWN_FRAMES     = 64
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       startGame,
  input  logic       playerHit,
  input  logic       levelDone,
  input  logic [3:0] arrowsIn,
  output logic [3:0] arrowsOut,
  output logic       respawnReq,
  output logic       visible,
  output logic [1:0] deathImage,
  output logic [2:0] lives,
  output logic [3:0] level,
  output logic       gameOver,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_READY       = 3'd1,
    S_PLAY        = 3'd2,
    S_DYING       = 3'd3,
    S_RESPAWN     = 3'd4,
    S_LEVEL_CLEAR = 3'd5,
    S_GAME_OVER   = 3'd6
  } state_t;

  // Last frameCnt value of each timed state; the transition fires on the
  // frame pulse seen while the counter holds this value.
  localparam logic [8:0] START_LAST   = 9'(START_DELAY_FRAMES - 1);
  localparam logic [8:0] DEATH_LAST   = 9'(DEATH_FRAMES - 1);
  localparam logic [8:0] RESPAWN_LAST = 9'(RESPAWN_FRAMES - 1);
  localparam logic [2:0] LIVES_INIT   = 3'(INITIAL_LIVES);

  state_t     cur_state;
  logic [8:0] frame_cnt;
  logic [2:0] lives_q;
  logic [3:0] level_q;
  logic       respawn_req_q;

  // Sequencer: state, frame counter, lives, level and the respawn strobe.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cur_state     <= S_IDLE;
      frame_cnt     <= 9'd0;
      lives_q       <= LIVES_INIT;
      level_q       <= 4'd0;
      respawn_req_q <= 1'b0;
    end else begin
      // The strobe is one cycle wide unless a transition below re-arms it.
      respawn_req_q <= 1'b0;
      case (cur_state)
        S_IDLE, S_GAME_OVER: begin
          if (startGame) begin
            cur_state     <= S_READY;
            frame_cnt     <= 9'd0;
            lives_q       <= LIVES_INIT;
            level_q       <= 4'd0;
            respawn_req_q <= 1'b1;
          end
        end
        S_READY: begin
          if (startOfFrame) begin
            if (frame_cnt == START_LAST) begin
              cur_state <= S_PLAY;
              frame_cnt <= 9'd0;
            end else begin
              frame_cnt <= frame_cnt + 9'd1;
            end
          end
        end
        S_PLAY: begin
          // A lethal hit outranks finishing the level in the same cycle.
          if (playerHit) begin
            cur_state <= S_DYING;
            frame_cnt <= 9'd0;
            if (lives_q != 3'd0) lives_q <= lives_q - 3'd1;
          end else if (levelDone) begin
            cur_state <= S_LEVEL_CLEAR;
            frame_cnt <= 9'd0;
            if (level_q != 4'd15) level_q <= level_q + 4'd1;
          end
        end
        S_DYING: begin
          if (startOfFrame) begin
            if (frame_cnt == DEATH_LAST) begin
              frame_cnt <= 9'd0;
              if (lives_q == 3'd0) begin
                cur_state <= S_GAME_OVER;
              end else begin
                cur_state     <= S_RESPAWN;
                respawn_req_q <= 1'b1;
              end
            end else begin
              frame_cnt <= frame_cnt + 9'd1;
            end
          end
        end
        S_RESPAWN: begin
          // Invulnerable: playerHit is not looked at here.
          if (levelDone) begin
            cur_state <= S_LEVEL_CLEAR;
            frame_cnt <= 9'd0;
            if (level_q != 4'd15) level_q <= level_q + 4'd1;
          end else if (startOfFrame) begin
            if (frame_cnt == RESPAWN_LAST) begin
              cur_state <= S_PLAY;
              frame_cnt <= 9'd0;
            end else begin
              frame_cnt <= frame_cnt + 9'd1;
            end
          end
        end
        S_LEVEL_CLEAR: begin
          if (startOfFrame) begin
            if (frame_cnt == START_LAST) begin
              cur_state     <= S_READY;
              frame_cnt     <= 9'd0;
              respawn_req_q <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt + 9'd1;
            end
          end
        end
        default: begin
          cur_state <= S_IDLE;
          frame_cnt <= 9'd0;
        end
      endcase
    end
  end

  // Output decode from registered state; no extra latency on the keys.
  always_comb begin
    arrowsOut  = 4'b0000;
    visible    = 1'b0;
    deathImage = 2'd0;
    gameOver   = 1'b0;
    case (cur_state)
      S_READY, S_LEVEL_CLEAR: visible = 1'b1;
      S_PLAY: begin
        arrowsOut = arrowsIn;
        visible   = 1'b1;
      end
      S_DYING: begin
        visible    = 1'b1;
        deathImage = frame_cnt[7:6];
      end
      S_RESPAWN: begin
        arrowsOut = arrowsIn;
        visible   = ~frame_cnt[2];
      end
      S_GAME_OVER: gameOver = 1'b1;
      default: ;
    endcase
  end

  assign respawnReq = respawn_req_q;
  assign lives      = lives_q;
  assign level      = level_q;
  assign state      = cur_state;

endmodule

// File: tb/tb_player_life_controller.sv
// Directed bench for player_life_controller with default parameters
// (3 lives, 32 / 256 / 64 frame delays). A frame pulse may be held high
// on consecutive cycles, so each such cycle counts as one frame.
module tb_player_life_controller;

  logic       clk;
  logic       resetN;
  logic       startOfFrame;
  logic       startGame;
  logic       playerHit;
  logic       levelDone;
  logic [3:0] arrowsIn;
  logic [3:0] arrowsOut;
  logic       respawnReq;
  logic       visible;
  logic [1:0] deathImage;
  logic [2:0] lives;
  logic [3:0] level;
  logic       gameOver;
  logic [2:0] state;

  int checks;
  int failures;

  player_life_controller dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .startGame    (startGame),
    .playerHit    (playerHit),
    .levelDone    (levelDone),
    .arrowsIn     (arrowsIn),
    .arrowsOut    (arrowsOut),
    .respawnReq   (respawnReq),
    .visible      (visible),
    .deathImage   (deathImage),
    .lives        (lives),
    .level        (level),
    .gameOver     (gameOver),
    .state        (state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         reps;
    logic       sg;
    logic       hit;
    logic       ld;
    logic       sof;
    logic [3:0] arr;
    int         e_state;
    int         e_lives;
    int         e_level;
    int         e_arrows;
    int         e_vis;
    int         e_rsp;
    int         e_dimg;
    int         e_go;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string nm, int reps, logic sg, logic hit, logic ld,
                              logic sof, logic [3:0] arr, int st, int lv, int lvl,
                              int ao, int vis, int rsp, int di, int go);
    vec_t v;
    v.name = nm; v.reps = reps; v.sg = sg; v.hit = hit; v.ld = ld; v.sof = sof;
    v.arr = arr; v.e_state = st; v.e_lives = lv; v.e_level = lvl; v.e_arrows = ao;
    v.e_vis = vis; v.e_rsp = rsp; v.e_dimg = di; v.e_go = go;
    vecs.push_back(v);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(string nm, int st, int lv, int lvl, int ao, int vis,
                         int rsp, int di, int go);
    chk({nm, ".state"}, 32'(state), st);
    chk({nm, ".lives"}, 32'(lives), lv);
    chk({nm, ".level"}, 32'(level), lvl);
    chk({nm, ".arrowsOut"}, 32'(arrowsOut), ao);
    chk({nm, ".visible"}, 32'(visible), vis);
    chk({nm, ".respawnReq"}, 32'(respawnReq), rsp);
    chk({nm, ".deathImage"}, 32'(deathImage), di);
    chk({nm, ".gameOver"}, 32'(gameOver), go);
  endtask

  // Driver: apply inputs at negedge, let one active edge pass, sample at +1.
  task automatic step(logic sg, logic hit, logic ld, logic sof, logic [3:0] arr);
    @(negedge clk);
    startGame    = sg;
    playerHit    = hit;
    levelDone    = ld;
    startOfFrame = sof;
    arrowsIn     = arr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    startGame = 0; playerHit = 0; levelDone = 0; startOfFrame = 0;
  endtask

  initial begin
    int exp_lvl;
    checks = 0;
    failures = 0;
    resetN = 1'b0;
    startGame = 0; playerHit = 0; levelDone = 0; startOfFrame = 0;
    arrowsIn = 4'b0100;

    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 0, 3, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    resetN = 1'b1;

    // name, reps, sg, hit, ld, sof, arrowsIn,
    // state, lives, level, arrowsOut, visible, respawnReq, deathImage, gameOver
    add("start",          1, 1, 0, 0, 0, 4'b0100, 1, 3, 0, 0,  1, 1, 0, 0);
    add("ready_hold",     1, 0, 0, 0, 0, 4'b0100, 1, 3, 0, 0,  1, 0, 0, 0);
    add("ready_31",      31, 0, 0, 0, 1, 4'b0100, 1, 3, 0, 0,  1, 0, 0, 0);
    add("play_entry",     1, 0, 0, 0, 1, 4'b0100, 2, 3, 0, 4,  1, 0, 0, 0);
    add("play_arrows",    5, 0, 0, 0, 0, 4'b1010, 2, 3, 0, 10, 1, 0, 0, 0);
    add("hit",            1, 0, 1, 0, 0, 4'b1010, 3, 2, 0, 0,  1, 0, 0, 0);
    add("dying_64",      64, 0, 0, 0, 1, 4'b0100, 3, 2, 0, 0,  1, 0, 1, 0);
    add("dying_128",     64, 0, 0, 0, 1, 4'b0100, 3, 2, 0, 0,  1, 0, 2, 0);
    add("dying_192",     64, 0, 0, 0, 1, 4'b0100, 3, 2, 0, 0,  1, 0, 3, 0);
    add("dying_255",     63, 0, 0, 0, 1, 4'b0100, 3, 2, 0, 0,  1, 0, 3, 0);
    add("respawn_entry",  1, 0, 0, 0, 1, 4'b0100, 4, 2, 0, 4,  1, 1, 0, 0);
    add("blink_off",      4, 0, 1, 0, 1, 4'b0100, 4, 2, 0, 4,  0, 0, 0, 0);
    add("blink_on",       4, 0, 1, 0, 1, 4'b0100, 4, 2, 0, 4,  1, 0, 0, 0);
    add("respawn_63",    55, 0, 1, 0, 1, 4'b0100, 4, 2, 0, 4,  0, 0, 0, 0);
    add("respawn_done",   1, 0, 0, 0, 1, 4'b0100, 2, 2, 0, 4,  1, 0, 0, 0);
    add("hit_beats_done", 1, 0, 1, 1, 0, 4'b0100, 3, 1, 0, 0,  1, 0, 0, 0);
    add("respawn2",     256, 0, 0, 0, 1, 4'b0100, 4, 1, 0, 4,  1, 1, 0, 0);
    add("clear_in_resp",  1, 0, 0, 1, 1, 4'b0100, 5, 1, 1, 0,  1, 0, 0, 0);
    add("clear_31",      31, 0, 0, 0, 1, 4'b0100, 5, 1, 1, 0,  1, 0, 0, 0);
    add("clear_to_ready", 1, 0, 0, 0, 1, 4'b0100, 1, 1, 1, 0,  1, 1, 0, 0);
    add("play2",         32, 0, 0, 0, 1, 4'b0100, 2, 1, 1, 4,  1, 0, 0, 0);
    add("last_hit",       1, 0, 1, 0, 0, 4'b0100, 3, 0, 1, 0,  1, 0, 0, 0);
    add("dying_last",   255, 0, 0, 0, 1, 4'b0100, 3, 0, 1, 0,  1, 0, 3, 0);
    add("game_over",      1, 0, 0, 0, 1, 4'b0100, 6, 0, 1, 0,  0, 0, 0, 1);
    add("go_ignore",      3, 0, 1, 1, 1, 4'b0100, 6, 0, 1, 0,  0, 0, 0, 1);
    add("restart",        1, 1, 0, 0, 0, 4'b0100, 1, 3, 0, 0,  1, 1, 0, 0);
    add("play_again",    32, 0, 0, 0, 1, 4'b0100, 2, 3, 0, 4,  1, 0, 0, 0);

    foreach (vecs[i]) begin
      for (int r = 0; r < vecs[i].reps; r++)
        step(vecs[i].sg, vecs[i].hit, vecs[i].ld, vecs[i].sof, vecs[i].arr);
      chk_all(vecs[i].name, vecs[i].e_state, vecs[i].e_lives, vecs[i].e_level,
              vecs[i].e_arrows, vecs[i].e_vis, vecs[i].e_rsp, vecs[i].e_dimg,
              vecs[i].e_go);
    end

    // Level counter saturation over 16 clears.
    for (int i = 1; i <= 16; i++) begin
      exp_lvl = (i > 15) ? 15 : i;
      step(0, 0, 1, 0, 4'b0001);
      chk("sat.clear_state", 32'(state), 5);
      chk("sat.level", 32'(level), exp_lvl);
      for (int r = 0; r < 32; r++) step(0, 0, 0, 1, 4'b0001);
      chk("sat.ready_state", 32'(state), 1);
      chk("sat.ready_rsp", 32'(respawnReq), 1);
      for (int r = 0; r < 32; r++) step(0, 0, 0, 1, 4'b0001);
      chk("sat.play_state", 32'(state), 2);
    end

    // Asynchronous reset in the middle of DYING.
    step(0, 1, 0, 0, 4'b0001);
    chk("mid.dying", 32'(state), 3);
    chk("mid.lives", 32'(lives), 2);
    for (int r = 0; r < 100; r++) step(0, 0, 0, 1, 4'b0001);
    chk("mid.dimg", 32'(deathImage), 1);
    idle_inputs();
    #2;
    resetN = 1'b0;
    #1;
    chk_all("async_reset", 0, 3, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    resetN = 1'b1;
    step(0, 0, 0, 1, 4'b0001);
    chk_all("post_reset", 0, 3, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
